preempt_quantum_ctrl: RTL and testbench

PREEMPT_QUANTUM_CTRL -- requirements
Module: preempt_quantum_ctrl

---
 rtl/preempt_quantum_ctrl_if.sv | 24 ++
 rtl/preempt_quantum_ctrl.sv | 81 ++++++++
 tb/tb_preempt_quantum_ctrl.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/preempt_quantum_ctrl_if.sv
// Bundle between the processor core and the time-slice controller: dispatch,
// retire and halt events in, OS-entry pulse, resume address and slice count out.
interface preempt_quantum_ctrl_if;
  logic        inicia_proc;
  logic        instr_valida;
  logic [31:0] pc_prox;
  logic        fim_proc;
  logic [15:0] quantum;
  logic        syscall;
  logic        swap_SO;
  logic [31:0] endRetRS;
  logic        em_proc;
  logic [15:0] contagem;

  modport master (
    output inicia_proc, instr_valida, pc_prox, fim_proc, quantum, syscall,
    input  swap_SO, endRetRS, em_proc, contagem
  );

  modport slave (
    input  inicia_proc, instr_valida, pc_prox, fim_proc, quantum, syscall,
    output swap_SO, endRetRS, em_proc, contagem
  );
endinterface

// File: rtl/preempt_quantum_ctrl.sv
// Time-slice preemption controller: counts retired user instructions and forces
// an OS entry when the quantum expires. Define SYSCALL_SWAP_EN to also swap on syscall.
module preempt_quantum_ctrl (
  input  logic                   clk,
  input  logic                   rst_n,
  preempt_quantum_ctrl_if.slave  bus
);
  typedef enum logic [1:0] {
    SO    = 2'd0,
    PROC  = 2'd1,
    TROCA = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] contagem_q, contagem_d;
  logic [31:0] end_ret_q, end_ret_d;
  logic        syscall_swap;
  logic        expire;
  logic [15:0] contagem_inc;

`ifdef SYSCALL_SWAP_EN
  assign syscall_swap = bus.syscall;
`else
  assign syscall_swap = bus.syscall & 1'b0;
`endif

  assign contagem_inc = contagem_q + 16'd1;
  // Equality (not >=) so a quantum lowered mid-slice waits for the counter to wrap.
  assign expire = (bus.quantum != 16'd0) && (contagem_q == bus.quantum - 16'd1);

  always_comb begin
    state_d    = state_q;
    contagem_d = contagem_q;
    end_ret_d  = end_ret_q;
    unique case (state_q)
      SO: begin
        if (bus.inicia_proc) begin
          state_d    = PROC;
          contagem_d = 16'd0;
        end
      end
      PROC: begin
        if (bus.fim_proc) begin
          state_d    = SO;
          contagem_d = 16'd0;
        end else if (bus.instr_valida) begin
          contagem_d = contagem_inc;
          if (syscall_swap || expire) begin
            state_d   = TROCA;
            end_ret_d = bus.pc_prox;
          end
        end
      end
      TROCA: begin
        state_d    = SO;
        contagem_d = 16'd0;
      end
      default: begin
        state_d    = SO;
        contagem_d = 16'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= SO;
      contagem_q <= 16'd0;
      end_ret_q  <= 32'd0;
    end else begin
      state_q    <= state_d;
      contagem_q <= contagem_d;
      end_ret_q  <= end_ret_d;
    end
  end

  assign bus.swap_SO  = (state_q == TROCA);
  assign bus.em_proc  = (state_q == PROC);
  assign bus.contagem = contagem_q;
  assign bus.endRetRS = end_ret_q;
endmodule

// File: tb/tb_preempt_quantum_ctrl.sv
// Directed bench for preempt_quantum_ctrl: a behavioural slice model checked
// every cycle, plus hand-computed expectations for the key scenarios.
module tb_preempt_quantum_ctrl;
  logic clk;
  logic rst_n;
  int   tests;
  int   fails;
  int   swaps;

  preempt_quantum_ctrl_if bus ();

  preempt_quantum_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      if (fails < 30)
        $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: who owns the CPU, whether an OS entry is being forced, slice count.
  bit          m_user;
  bit          m_entering_os;
  int unsigned m_count;
  logic [31:0] m_resume;
  bit          m_sys_en;
  int unsigned nxt;

`ifdef SYSCALL_SWAP_EN
  initial m_sys_en = 1'b1;
`else
  initial m_sys_en = 1'b0;
`endif

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_user        <= 1'b0;
      m_entering_os <= 1'b0;
      m_count       <= 0;
      m_resume      <= 32'd0;
    end else if (m_entering_os) begin
      m_entering_os <= 1'b0;
      m_count       <= 0;
    end else if (!m_user) begin
      if (bus.inicia_proc) begin
        m_user  <= 1'b1;
        m_count <= 0;
      end
    end else if (bus.fim_proc) begin
      m_user  <= 1'b0;
      m_count <= 0;
    end else if (bus.instr_valida) begin
      nxt = (m_count + 1) % 65536;
      m_count <= nxt;
      if ((m_sys_en && bus.syscall) || (bus.quantum != 0 && nxt == bus.quantum)) begin
        m_user        <= 1'b0;
        m_entering_os <= 1'b1;
        m_resume      <= bus.pc_prox;
      end
    end
  end

  always @(negedge clk) begin
    chk("swap_SO", {31'd0, bus.swap_SO}, {31'd0, m_entering_os});
    chk("em_proc", {31'd0, bus.em_proc}, {31'd0, m_user});
    chk("contagem", {16'd0, bus.contagem}, m_count);
    chk("endRetRS", bus.endRetRS, m_resume);
    if (bus.swap_SO === 1'b1) swaps++;
  end

  // Apply one cycle of inputs; returns 1 time unit after the consuming edge.
  task automatic cyc(input bit ini, input bit iv, input bit fim, input bit sc, input logic [31:0] pc);
    bus.inicia_proc  = ini;
    bus.instr_valida = iv;
    bus.fim_proc     = fim;
    bus.syscall      = sc;
    bus.pc_prox      = pc;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    rst_n = 1'b1;
    cyc(0, 0, 0, 0, 0);
  endtask

  int em_cycles;
  int swaps_before;

  initial begin
    tests = 0;
    fails = 0;
    swaps = 0;
    rst_n = 1'b0;
    bus.quantum = 16'd3;
    cyc(0, 0, 0, 0, 0);
    chk("reset_em_proc", {31'd0, bus.em_proc}, 32'd0);
    chk("reset_endRetRS", bus.endRetRS, 32'd0);
    chk("reset_contagem", {16'd0, bus.contagem}, 32'd0);
    do_reset();
    chk("idle_after_reset_em_proc", {31'd0, bus.em_proc}, 32'd0);

    // Quantum 3: expiry on the third retire, resume address 202.
    em_cycles = 0;
    cyc(1, 0, 0, 0, 0);
    if (bus.em_proc) em_cycles++;
    cyc(0, 1, 0, 0, 200);
    if (bus.em_proc) em_cycles++;
    cyc(0, 1, 0, 0, 201);
    if (bus.em_proc) em_cycles++;
    cyc(0, 1, 0, 0, 202);
    if (bus.em_proc) em_cycles++;
    chk("q3_swap_pulse", {31'd0, bus.swap_SO}, 32'd1);
    chk("q3_endRetRS", bus.endRetRS, 32'd202);
    chk("q3_em_cycles", em_cycles, 32'd3);
    cyc(0, 0, 0, 0, 0);
    chk("q3_swap_one_cycle", {31'd0, bus.swap_SO}, 32'd0);
    chk("q3_back_in_so", {31'd0, bus.em_proc}, 32'd0);

    // Halt coincident with the expiring retire wins.
    do_reset();
    bus.quantum = 16'd2;
    swaps_before = swaps;
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 54);
    cyc(0, 1, 1, 0, 55);
    chk("fim_swap", {31'd0, bus.swap_SO}, 32'd0);
    chk("fim_em_proc", {31'd0, bus.em_proc}, 32'd0);
    chk("fim_endRetRS", bus.endRetRS, 32'd0);
    cyc(0, 0, 0, 0, 0);
    chk("fim_no_pulse", swaps - swaps_before, 32'd0);

    // Reset in the middle of a slice.
    do_reset();
    bus.quantum = 16'd5;
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 10);
    cyc(0, 1, 0, 0, 11);
    chk("pre_rst_contagem", {16'd0, bus.contagem}, 32'd2);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_em_proc", {31'd0, bus.em_proc}, 32'd0);
    chk("async_rst_contagem", {16'd0, bus.contagem}, 32'd0);
    chk("async_rst_swap", {31'd0, bus.swap_SO}, 32'd0);
    #1 rst_n = 1'b1;
    swaps_before = swaps;
    for (int i = 0; i < 6; i++) cyc(0, 1, 0, 0, 32'(20 + i));
    chk("post_rst_no_swap", swaps - swaps_before, 32'd0);
    chk("post_rst_stays_so", {31'd0, bus.em_proc}, 32'd0);

    // Syscall on the first instruction.
    do_reset();
    bus.quantum = 16'd10;
    swaps_before = swaps;
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 0, 1, 32'h40);
`ifdef SYSCALL_SWAP_EN
    chk("sys_swap", {31'd0, bus.swap_SO}, 32'd1);
    chk("sys_endRetRS", bus.endRetRS, 32'h40);
`else
    chk("sys_ignored_swap", {31'd0, bus.swap_SO}, 32'd0);
    chk("sys_ignored_contagem", {16'd0, bus.contagem}, 32'd1);
`endif
    cyc(0, 0, 0, 0, 0);

    // inicia_proc held high: re-dispatch only from SO with a fresh count.
    do_reset();
    bus.quantum = 16'd2;
    cyc(1, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 300);
    cyc(1, 1, 0, 0, 301);
    chk("hold_swap", {31'd0, bus.swap_SO}, 32'd1);
    cyc(1, 0, 0, 0, 0);
    chk("hold_in_so", {31'd0, bus.em_proc}, 32'd0);
    cyc(1, 0, 0, 0, 0);
    chk("hold_redispatch", {31'd0, bus.em_proc}, 32'd1);
    chk("hold_redispatch_cnt", {16'd0, bus.contagem}, 32'd0);

    // Quantum lowered below the running count: no expiry for a while.
    cyc(0, 0, 1, 0, 0);
    bus.quantum = 16'd10;
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 1, 0, 0, 32'(400 + i));
    bus.quantum = 16'd3;
    swaps_before = swaps;
    for (int i = 0; i < 8; i++) cyc(0, 1, 0, 0, 32'(500 + i));
    chk("lowered_q_no_swap", swaps - swaps_before, 32'd0);
    chk("lowered_q_contagem", {16'd0, bus.contagem}, 32'd13);
    cyc(0, 0, 1, 0, 0);

    // Quantum 0: preemption disabled, counter wraps.
    do_reset();
    bus.quantum = 16'd0;
    swaps_before = swaps;
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 70000; i++) cyc(0, 1, 0, 0, 32'(i));
    chk("q0_no_swap", swaps - swaps_before, 32'd0);
    chk("q0_contagem_wrap", {16'd0, bus.contagem}, 32'd4464);
    chk("q0_still_proc", {31'd0, bus.em_proc}, 32'd1);
    cyc(0, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
